// File: rtl/atom_mem_arbiter.sv
// Two-to-one valid/ack arbiter merging the instruction-fetch and data ports onto one memory slave.
// Grants are locked until slave ack, owner abort, or a watchdog-forced error ack.
module atom_mem_arbiter #(
    parameter bit          FAIR_RR        = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] imem_addr_i,
    input  logic        imem_valid_i,
    output logic [31:0] imem_data_o,
    output logic        imem_ack_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    input  logic [3:0]  dmem_sel_i,
    input  logic        dmem_we_i,
    input  logic        dmem_valid_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_ack_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_o,
    output logic [3:0]  m_sel_o,
    output logic        m_we_o,
    output logic        m_valid_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t                 state_q, state_d;
    logic                   last_gnt_q, last_gnt_d;
    logic [TIMEOUT_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic        own_i, own_d;
    logic        m_valid;
    logic        slave_ack;
    logic        wd_hit;
    logic        done;
    logic [31:0] rdata;

    // Owner selection; gating with rst_ni forces every output low while reset is held.
    always_comb begin
        own_i = 1'b0;
        own_d = 1'b0;
        case (state_q)
            GNT_I: own_i = 1'b1;
            GNT_D: own_d = 1'b1;
            default: begin
                if (imem_valid_i && dmem_valid_i) begin
                    if (FAIR_RR && last_gnt_q) own_i = 1'b1;
                    else                       own_d = 1'b1;
                end else if (dmem_valid_i) begin
                    own_d = 1'b1;
                end else if (imem_valid_i) begin
                    own_i = 1'b1;
                end
            end
        endcase
        own_i = own_i & rst_ni;
        own_d = own_d & rst_ni;
    end

    always_comb begin
        m_valid   = (own_i & imem_valid_i) | (own_d & dmem_valid_i);
        slave_ack = m_ack_i & m_valid;
        // A real slave ack in the expiry cycle takes precedence over the forced ack.
        wd_hit    = (TIMEOUT_CYCLES != 0) && m_valid && !m_ack_i &&
                    (wd_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));
        done      = slave_ack | wd_hit;
        rdata     = wd_hit ? 32'h0 : m_data_i;
    end

    always_comb begin
        m_valid_o   = m_valid;
        m_addr_o    = own_d ? dmem_addr_i : (own_i ? imem_addr_i : 32'h0);
        m_data_o    = own_d ? dmem_data_i : 32'h0;
        m_sel_o     = own_d ? dmem_sel_i : (own_i ? 4'hF : 4'h0);
        m_we_o      = own_d & dmem_we_i;
        imem_data_o = own_i ? rdata : 32'h0;
        dmem_data_o = own_d ? rdata : 32'h0;
        imem_ack_o  = own_i & done;
        dmem_ack_o  = own_d & done;
        timeout_o   = wd_hit;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wd_cnt_d   = wd_cnt_q;
        if (!m_valid) begin
            // Idle or owner withdrew valid: abort without touching last_gnt.
            state_d  = IDLE;
            wd_cnt_d = '0;
        end else if (done) begin
            state_d    = IDLE;
            last_gnt_d = own_d;
            wd_cnt_d   = '0;
        end else begin
            state_d = own_d ? GNT_D : GNT_I;
            if (wd_cnt_q != {TIMEOUT_W{1'b1}}) wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Directed bench for atom_mem_arbiter with round-robin enabled and a 4-cycle watchdog.
module tb_atom_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_i;
    logic        imem_valid_i;
    logic [31:0] imem_data_o;
    logic        imem_ack_o;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [3:0]  dmem_sel_i;
    logic        dmem_we_i;
    logic        dmem_valid_i;
    logic [31:0] dmem_data_o;
    logic        dmem_ack_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o;
    logic        m_valid_o;
    logic [31:0] m_data_i;
    logic        m_ack_i;
    logic        timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    atom_mem_arbiter #(
        .FAIR_RR        (1'b1),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_W      (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_addr_i  (imem_addr_i),
        .imem_valid_i (imem_valid_i),
        .imem_data_o  (imem_data_o),
        .imem_ack_o   (imem_ack_o),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_data_i  (dmem_data_i),
        .dmem_sel_i   (dmem_sel_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_valid_i (dmem_valid_i),
        .dmem_data_o  (dmem_data_o),
        .dmem_ack_o   (dmem_ack_o),
        .m_addr_o     (m_addr_o),
        .m_data_o     (m_data_o),
        .m_sel_o      (m_sel_o),
        .m_we_o       (m_we_o),
        .m_valid_o    (m_valid_o),
        .m_data_i     (m_data_i),
        .m_ack_i      (m_ack_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        imem_addr_i  = 32'h0;
        imem_valid_i = 1'b1;
        dmem_addr_i  = 32'h0;
        dmem_data_i  = 32'h0;
        dmem_sel_i   = 4'h0;
        dmem_we_i    = 1'b0;
        dmem_valid_i = 1'b0;
        m_data_i     = 32'hDEAD_BEEF;
        m_ack_i      = 1'b1;

        // Reset held: outputs must be zero even with a request and slave ack present.
        #2;
        chk("rst_m_valid", 32'(m_valid_o), 32'h0);
        chk("rst_imem_ack", 32'(imem_ack_o), 32'h0);
        chk("rst_imem_data", imem_data_o, 32'h0);
        chk("rst_m_sel", 32'(m_sel_o), 32'h0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;

        // Conflict after reset, slave acks every cycle: dmem, imem, dmem, imem.
        imem_valid_i = 1'b1; imem_addr_i = 32'h0001_0000;
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_2000;
        dmem_data_i  = 32'hA5A5_A5A5; dmem_sel_i = 4'b0001; dmem_we_i = 1'b1;
        m_ack_i = 1'b1; m_data_i = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (i % 2 == 0) begin
                chk($sformatf("rr%0d_addr", i), m_addr_o, 32'h0000_2000);
                chk($sformatf("rr%0d_wdata", i), m_data_o, 32'hA5A5_A5A5);
                chk($sformatf("rr%0d_sel", i), 32'(m_sel_o), 32'h1);
                chk($sformatf("rr%0d_we", i), 32'(m_we_o), 32'h1);
                chk($sformatf("rr%0d_dack", i), 32'(dmem_ack_o), 32'h1);
                chk($sformatf("rr%0d_iack", i), 32'(imem_ack_o), 32'h0);
            end else begin
                chk($sformatf("rr%0d_addr", i), m_addr_o, 32'h0001_0000);
                chk($sformatf("rr%0d_wdata", i), m_data_o, 32'h0);
                chk($sformatf("rr%0d_sel", i), 32'(m_sel_o), 32'hF);
                chk($sformatf("rr%0d_we", i), 32'(m_we_o), 32'h0);
                chk($sformatf("rr%0d_iack", i), 32'(imem_ack_o), 32'h1);
                chk($sformatf("rr%0d_idata", i), imem_data_o, 32'h13);
                chk($sformatf("rr%0d_dack", i), 32'(dmem_ack_o), 32'h0);
            end
            next_cycle();
        end

        // Single-cycle fetch (last grant stays imem).
        dmem_valid_i = 1'b0; dmem_we_i = 1'b0; dmem_sel_i = 4'hF;
        @(negedge clk_i);
        chk("sf_addr", m_addr_o, 32'h0001_0000);
        chk("sf_idata", imem_data_o, 32'h13);
        chk("sf_iack", 32'(imem_ack_o), 32'h1);
        chk("sf_dack", 32'(dmem_ack_o), 32'h0);
        next_cycle();

        // Abort: dmem stalls two cycles then withdraws; a stray slave ack is ignored.
        imem_valid_i = 1'b0;
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_2008;
        m_ack_i = 1'b0;
        @(negedge clk_i);
        chk("ab0_valid", 32'(m_valid_o), 32'h1);
        chk("ab0_addr", m_addr_o, 32'h0000_2008);
        chk("ab0_dack", 32'(dmem_ack_o), 32'h0);
        next_cycle();
        @(negedge clk_i);
        chk("ab1_valid", 32'(m_valid_o), 32'h1);
        next_cycle();
        dmem_valid_i = 1'b0; m_ack_i = 1'b1;
        @(negedge clk_i);
        chk("ab2_valid", 32'(m_valid_o), 32'h0);
        chk("ab2_dack", 32'(dmem_ack_o), 32'h0);
        chk("ab2_iack", 32'(imem_ack_o), 32'h0);
        next_cycle();
        // Back in IDLE with last grant still imem, so dmem wins the conflict.
        imem_valid_i = 1'b1; dmem_valid_i = 1'b1; m_data_i = 32'h0000_0042;
        @(negedge clk_i);
        chk("ab3_dack", 32'(dmem_ack_o), 32'h1);
        chk("ab3_ddata", dmem_data_o, 32'h42);
        chk("ab3_iack", 32'(imem_ack_o), 32'h0);
        next_cycle();

        // Lock: imem granted, ack delayed 3 cycles, dmem arrives in cycle 1.
        imem_addr_i = 32'h0001_0040; dmem_valid_i = 1'b0; dmem_addr_i = 32'h0000_2004;
        m_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) dmem_valid_i = 1'b1;
            if (i == 3) begin m_ack_i = 1'b1; m_data_i = 32'h0000_0055; end
            @(negedge clk_i);
            chk($sformatf("lk%0d_addr", i), m_addr_o, 32'h0001_0040);
            chk($sformatf("lk%0d_dack", i), 32'(dmem_ack_o), 32'h0);
            chk($sformatf("lk%0d_iack", i), 32'(imem_ack_o), (i == 3) ? 32'h1 : 32'h0);
            next_cycle();
        end
        imem_valid_i = 1'b0; m_data_i = 32'h0000_0066;
        @(negedge clk_i);
        chk("lk4_addr", m_addr_o, 32'h0000_2004);
        chk("lk4_dack", 32'(dmem_ack_o), 32'h1);
        chk("lk4_ddata", dmem_data_o, 32'h66);
        next_cycle();

        // Watchdog: imem stalls 4 cycles, forced ack with zero data in the 5th.
        dmem_valid_i = 1'b0; imem_valid_i = 1'b1; imem_addr_i = 32'h0001_0080;
        m_ack_i = 1'b0; m_data_i = 32'h0000_0099;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("wd%0d_iack", i), 32'(imem_ack_o), 32'h0);
            chk($sformatf("wd%0d_to", i), 32'(timeout_o), 32'h0);
            next_cycle();
        end
        @(negedge clk_i);
        chk("wd4_iack", 32'(imem_ack_o), 32'h1);
        chk("wd4_idata", imem_data_o, 32'h0);
        chk("wd4_to", 32'(timeout_o), 32'h1);
        next_cycle();
        @(negedge clk_i);
        chk("wd5_to", 32'(timeout_o), 32'h0);
        chk("wd5_iack", 32'(imem_ack_o), 32'h0);
        next_cycle();
        imem_valid_i = 1'b0;
        next_cycle();

        // Watchdog expiry coincides with a real ack: real data, no timeout pulse.
        dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_200C;
        m_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("wr%0d_dack", i), 32'(dmem_ack_o), 32'h0);
            next_cycle();
        end
        m_ack_i = 1'b1; m_data_i = 32'h0000_1234;
        @(negedge clk_i);
        chk("wr4_dack", 32'(dmem_ack_o), 32'h1);
        chk("wr4_ddata", dmem_data_o, 32'h1234);
        chk("wr4_to", 32'(timeout_o), 32'h0);
        next_cycle();

        // Reset mid-transaction while in GNT_D; last grant is dmem beforehand.
        dmem_addr_i = 32'h0000_2010; dmem_sel_i = 4'hF; m_ack_i = 1'b0;
        next_cycle();
        #2;
        rst_ni = 1'b0;
        m_ack_i = 1'b1;
        #1;
        chk("mr_m_valid", 32'(m_valid_o), 32'h0);
        chk("mr_m_addr", m_addr_o, 32'h0);
        chk("mr_m_sel", 32'(m_sel_o), 32'h0);
        chk("mr_dack", 32'(dmem_ack_o), 32'h0);
        chk("mr_ddata", dmem_data_o, 32'h0);
        next_cycle();
        rst_ni = 1'b1;
        imem_valid_i = 1'b1; dmem_valid_i = 1'b1; m_data_i = 32'h0000_0077;
        @(negedge clk_i);
        chk("mr_post_dack", 32'(dmem_ack_o), 32'h1);
        chk("mr_post_iack", 32'(imem_ack_o), 32'h0);
        chk("mr_post_addr", m_addr_o, 32'h0000_2010);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
